// File: rtl/ibex_defines.sv
// Shared type definitions for the execute-stage slice: ALU / mult-div operator
// encodings and the issue sequencer state.
package ibex_defines;

    typedef enum logic [5:0] {
        ALU_ADD = 6'd0,
        ALU_SUB = 6'd1,
        ALU_XOR = 6'd2,
        ALU_OR  = 6'd3,
        ALU_AND = 6'd4,
        ALU_SRA = 6'd5,
        ALU_SRL = 6'd6,
        ALU_SLL = 6'd7,
        ALU_LT  = 6'd8,
        ALU_LTU = 6'd9,
        ALU_EQ  = 6'd10,
        ALU_NE  = 6'd11
    } alu_op_e;

    typedef enum logic [1:0] {
        MD_OP_MULL = 2'd0,
        MD_OP_MULH = 2'd1,
        MD_OP_DIV  = 2'd2,
        MD_OP_REM  = 2'd3
    } md_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } issue_state_e;

    // x0 is hardwired to zero, so writes to it are never emitted
    function automatic logic wb_needed(input logic we, input logic [4:0] waddr);
        return we & (waddr != 5'd0);
    endfunction

endpackage

// File: rtl/ibex_ex_stall_counter.sv
// Free-running 32-bit counter of mult/div stall cycles; wraps, cleared only by reset.
// Instantiated by ibex_ex_issue when IBEX_EX_ISSUE_STALL_CNT_EN is defined.
module ibex_ex_stall_counter (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        inc_i,
    output logic [31:0] cnt_o
);

    logic [31:0] cnt_r;

    // Stall cycle accumulator
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_r <= 32'd0;
        end else if (inc_i) begin
            cnt_r <= cnt_r + 32'd1;
        end
    end

    assign cnt_o = cnt_r;

endmodule

// File: rtl/ibex_ex_issue.sv
// Issue/writeback sequencer between decoder and ibex_ex_block.
// Optional mult/div stall counter enabled by defining IBEX_EX_ISSUE_STALL_CNT_EN.
module ibex_ex_issue
    import ibex_defines::*;
#(
    parameter bit RV32M = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        instr_valid_i,
    output logic        instr_ready_o,
    input  alu_op_e     alu_operator_i,
    input  md_op_e      md_operator_i,
    input  logic        mult_sel_i,
    input  logic        div_sel_i,
    input  logic [1:0]  md_signed_mode_i,
    input  logic [31:0] operand_a_i,
    input  logic [31:0] operand_b_i,
    input  logic        rf_we_i,
    input  logic [4:0]  rf_waddr_i,
    input  logic        flush_i,

    output alu_op_e     alu_operator_o,
    output logic [31:0] alu_operand_a_o,
    output logic [31:0] alu_operand_b_o,
    output md_op_e      multdiv_operator_o,
    output logic        mult_en_o,
    output logic        div_en_o,
    output logic [1:0]  multdiv_signed_mode_o,
    output logic [31:0] multdiv_operand_a_o,
    output logic [31:0] multdiv_operand_b_o,

    input  logic [31:0] regfile_wdata_ex_i,
    input  logic        ex_valid_i,

    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,

    output logic        busy_o,
    output logic [31:0] md_stall_cnt_o
);

    issue_state_e state_r;
    issue_state_e next_state_s;

    alu_op_e      alu_op_r;
    md_op_e       md_op_r;
    logic [1:0]   signed_mode_r;
    logic [31:0]  op_a_r;
    logic [31:0]  op_b_r;
    logic         held_we_r;
    logic [4:0]   held_waddr_r;
    logic         mult_en_r;
    logic         div_en_r;

    logic         rf_we_r;
    logic [4:0]   rf_waddr_r;
    logic [31:0]  rf_wdata_r;

    logic         ready_s;
    logic         accept_s;
    logic         complete_s;
    logic         held_md_s;

    assign held_md_s  = mult_en_r | div_en_r;
    assign accept_s   = instr_valid_i & ready_s;
    assign complete_s = (state_r == EXEC) & ex_valid_i & ~flush_i;

    // Ready: mult/div completions must pass through IDLE so the enables drop
    always_comb begin
        ready_s = 1'b0;
        if (flush_i) begin
            ready_s = 1'b0;
        end else begin
            case (state_r)
                IDLE:    ready_s = 1'b1;
                EXEC:    ready_s = ex_valid_i & ~held_md_s;
                default: ready_s = 1'b0;
            endcase
        end
    end

    // Next-state logic; flush overrides everything
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    next_state_s = EXEC;
                end else begin
                    next_state_s = IDLE;
                end
            end
            EXEC: begin
                if (accept_s) begin
                    next_state_s = EXEC;
                end else if (ex_valid_i) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = EXEC;
                end
            end
            default: next_state_s = IDLE;
        endcase
        if (flush_i) begin
            next_state_s = IDLE;
        end else begin
            next_state_s = next_state_s;
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Issue register: operands and control captured on accept, held while executing
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            alu_op_r      <= ALU_ADD;
            md_op_r       <= MD_OP_MULL;
            signed_mode_r <= 2'd0;
            op_a_r        <= 32'd0;
            op_b_r        <= 32'd0;
            held_we_r     <= 1'b0;
            held_waddr_r  <= 5'd0;
        end else if (accept_s) begin
            alu_op_r      <= alu_operator_i;
            md_op_r       <= md_operator_i;
            signed_mode_r <= md_signed_mode_i;
            op_a_r        <= operand_a_i;
            op_b_r        <= operand_b_i;
            held_we_r     <= rf_we_i;
            held_waddr_r  <= rf_waddr_i;
        end
    end

    // Mult/div enables: set on accept, dropped on completion or flush
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mult_en_r <= 1'b0;
            div_en_r  <= 1'b0;
        end else if (accept_s) begin
            mult_en_r <= RV32M & mult_sel_i;
            div_en_r  <= RV32M & div_sel_i;
        end else if (flush_i || ((state_r == EXEC) && ex_valid_i)) begin
            mult_en_r <= 1'b0;
            div_en_r  <= 1'b0;
        end
    end

    // Writeback register: one-cycle strobe; address/data only move on a real write
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rf_we_r    <= 1'b0;
            rf_waddr_r <= 5'd0;
            rf_wdata_r <= 32'd0;
        end else begin
            rf_we_r <= complete_s & wb_needed(held_we_r, held_waddr_r);
            if (complete_s && wb_needed(held_we_r, held_waddr_r)) begin
                rf_waddr_r <= held_waddr_r;
                rf_wdata_r <= regfile_wdata_ex_i;
            end
        end
    end

`ifdef IBEX_EX_ISSUE_STALL_CNT_EN
    logic stall_inc_s;
    assign stall_inc_s = (state_r == EXEC) & held_md_s & ~ex_valid_i;

    ibex_ex_stall_counter u_stall_counter (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (stall_inc_s),
        .cnt_o  (md_stall_cnt_o)
    );
`else
    assign md_stall_cnt_o = 32'd0;
`endif

    assign instr_ready_o         = ready_s;
    assign alu_operator_o        = alu_op_r;
    assign alu_operand_a_o       = op_a_r;
    assign alu_operand_b_o       = op_b_r;
    assign multdiv_operator_o    = md_op_r;
    assign mult_en_o             = mult_en_r;
    assign div_en_o              = div_en_r;
    assign multdiv_signed_mode_o = signed_mode_r;
    assign multdiv_operand_a_o   = op_a_r;
    assign multdiv_operand_b_o   = op_b_r;
    assign rf_we_o               = rf_we_r;
    assign rf_waddr_o            = rf_waddr_r;
    assign rf_wdata_o            = rf_wdata_r;
    assign busy_o                = (state_r != IDLE);

endmodule

// File: tb/tb_ibex_ex_issue.sv
// Directed self-checking bench for ibex_ex_issue; inputs change and outputs are
// sampled on the falling edge. Honours IBEX_EX_ISSUE_STALL_CNT_EN for counter expectations.
module tb_ibex_ex_issue;
    import ibex_defines::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        instr_valid_i;
    logic        instr_ready_o;
    alu_op_e     alu_operator_i;
    md_op_e      md_operator_i;
    logic        mult_sel_i;
    logic        div_sel_i;
    logic [1:0]  md_signed_mode_i;
    logic [31:0] operand_a_i;
    logic [31:0] operand_b_i;
    logic        rf_we_i;
    logic [4:0]  rf_waddr_i;
    logic        flush_i;
    alu_op_e     alu_operator_o;
    logic [31:0] alu_operand_a_o;
    logic [31:0] alu_operand_b_o;
    md_op_e      multdiv_operator_o;
    logic        mult_en_o;
    logic        div_en_o;
    logic [1:0]  multdiv_signed_mode_o;
    logic [31:0] multdiv_operand_a_o;
    logic [31:0] multdiv_operand_b_o;
    logic [31:0] regfile_wdata_ex_i;
    logic        ex_valid_i;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        busy_o;
    logic [31:0] md_stall_cnt_o;

    int checks = 0;
    int errors = 0;

`ifdef IBEX_EX_ISSUE_STALL_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    always #5 clk_i = ~clk_i;

    ibex_ex_issue dut (
        .clk_i                 (clk_i),
        .rst_ni                (rst_ni),
        .instr_valid_i         (instr_valid_i),
        .instr_ready_o         (instr_ready_o),
        .alu_operator_i        (alu_operator_i),
        .md_operator_i         (md_operator_i),
        .mult_sel_i            (mult_sel_i),
        .div_sel_i             (div_sel_i),
        .md_signed_mode_i      (md_signed_mode_i),
        .operand_a_i           (operand_a_i),
        .operand_b_i           (operand_b_i),
        .rf_we_i               (rf_we_i),
        .rf_waddr_i            (rf_waddr_i),
        .flush_i               (flush_i),
        .alu_operator_o        (alu_operator_o),
        .alu_operand_a_o       (alu_operand_a_o),
        .alu_operand_b_o       (alu_operand_b_o),
        .multdiv_operator_o    (multdiv_operator_o),
        .mult_en_o             (mult_en_o),
        .div_en_o              (div_en_o),
        .multdiv_signed_mode_o (multdiv_signed_mode_o),
        .multdiv_operand_a_o   (multdiv_operand_a_o),
        .multdiv_operand_b_o   (multdiv_operand_b_o),
        .regfile_wdata_ex_i    (regfile_wdata_ex_i),
        .ex_valid_i            (ex_valid_i),
        .rf_we_o               (rf_we_o),
        .rf_waddr_o            (rf_waddr_o),
        .rf_wdata_o            (rf_wdata_o),
        .busy_o                (busy_o),
        .md_stall_cnt_o        (md_stall_cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive_op(input alu_op_e aop, input md_op_e mop, input logic ms, input logic ds,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic we, input logic [4:0] rd);
        instr_valid_i    = 1'b1;
        alu_operator_i   = aop;
        md_operator_i    = mop;
        mult_sel_i       = ms;
        div_sel_i        = ds;
        md_signed_mode_i = 2'd0;
        operand_a_i      = a;
        operand_b_i      = b;
        rf_we_i          = we;
        rf_waddr_i       = rd;
    endtask

    task automatic drop_valid();
        instr_valid_i = 1'b0;
        mult_sel_i    = 1'b0;
        div_sel_i     = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0;
        flush_i = 1'b0;
        ex_valid_i = 1'b0;
        regfile_wdata_ex_i = 32'd0;
        drive_op(ALU_ADD, MD_OP_MULL, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 5'd0);
        drop_valid();
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // reset state
        chk("rst_busy", busy_o, 32'd0);
        chk("rst_ready", instr_ready_o, 32'd1);
        chk("rst_rf_we", rf_we_o, 32'd0);
        chk("rst_waddr", rf_waddr_o, 32'd0);
        chk("rst_wdata", rf_wdata_o, 32'd0);
        chk("rst_mult_en", mult_en_o, 32'd0);
        chk("rst_div_en", div_en_o, 32'd0);
        chk("rst_alu_op", alu_operator_o, ALU_ADD);
        chk("rst_md_op", multdiv_operator_o, MD_OP_MULL);
        chk("rst_opa", alu_operand_a_o, 32'd0);
        chk("rst_stall", md_stall_cnt_o, 32'd0);

        // single ALU add 5+7 -> x3, ex_valid tied high
        drive_op(ALU_ADD, MD_OP_MULL, 1'b0, 1'b0, 32'd5, 32'd7, 1'b1, 5'd3);
        ex_valid_i = 1'b1;
        regfile_wdata_ex_i = 32'd12;
        #1 chk("add_ready", instr_ready_o, 32'd1);
        @(negedge clk_i);
        drop_valid();
        chk("add_busy", busy_o, 32'd1);
        chk("add_alu_a", alu_operand_a_o, 32'd5);
        chk("add_alu_b", alu_operand_b_o, 32'd7);
        chk("add_md_a", multdiv_operand_a_o, 32'd5);
        chk("add_mult_en", mult_en_o, 32'd0);
        chk("add_no_early_we", rf_we_o, 32'd0);
        @(negedge clk_i);
        chk("add_we", rf_we_o, 32'd1);
        chk("add_waddr", rf_waddr_o, 32'd3);
        chk("add_wdata", rf_wdata_o, 32'd12);
        chk("add_idle", busy_o, 32'd0);
        @(negedge clk_i);
        chk("add_we_pulse", rf_we_o, 32'd0);

        // three back-to-back ALU ops
        drive_op(ALU_ADD, MD_OP_MULL, 1'b0, 1'b0, 32'd1, 32'd2, 1'b1, 5'd5);
        #1 chk("b2b_ready0", instr_ready_o, 32'd1);
        @(negedge clk_i);
        chk("b2b_opa1", alu_operand_a_o, 32'd1);
        drive_op(ALU_SUB, MD_OP_MULL, 1'b0, 1'b0, 32'd3, 32'd4, 1'b1, 5'd6);
        regfile_wdata_ex_i = 32'd100;
        #1 chk("b2b_ready1", instr_ready_o, 32'd1);
        @(negedge clk_i);
        chk("b2b_we1", rf_we_o, 32'd1);
        chk("b2b_waddr1", rf_waddr_o, 32'd5);
        chk("b2b_wdata1", rf_wdata_o, 32'd100);
        chk("b2b_opa2", alu_operand_a_o, 32'd3);
        chk("b2b_aluop2", alu_operator_o, ALU_SUB);
        drive_op(ALU_XOR, MD_OP_MULL, 1'b0, 1'b0, 32'd5, 32'd6, 1'b1, 5'd7);
        regfile_wdata_ex_i = 32'd101;
        #1 chk("b2b_ready2", instr_ready_o, 32'd1);
        @(negedge clk_i);
        chk("b2b_we2", rf_we_o, 32'd1);
        chk("b2b_waddr2", rf_waddr_o, 32'd6);
        chk("b2b_wdata2", rf_wdata_o, 32'd101);
        chk("b2b_opa3", alu_operand_a_o, 32'd5);
        drop_valid();
        regfile_wdata_ex_i = 32'd102;
        @(negedge clk_i);
        chk("b2b_we3", rf_we_o, 32'd1);
        chk("b2b_waddr3", rf_waddr_o, 32'd7);
        chk("b2b_wdata3", rf_wdata_o, 32'd102);
        chk("b2b_idle", busy_o, 32'd0);

        // MUL x4, EX valid on the third execute cycle
        ex_valid_i = 1'b0;
        drive_op(ALU_ADD, MD_OP_MULL, 1'b1, 1'b0, 32'h10, 32'h20, 1'b1, 5'd4);
        #1 chk("mul_ready_idle", instr_ready_o, 32'd1);
        @(negedge clk_i);
        drop_valid();
        chk("mul_en_c1", mult_en_o, 32'd1);
        chk("mul_div_en_c1", div_en_o, 32'd0);
        chk("mul_md_a", multdiv_operand_a_o, 32'h10);
        chk("mul_md_b", multdiv_operand_b_o, 32'h20);
        chk("mul_ready_c1", instr_ready_o, 32'd0);
        chk("mul_no_we_c1", rf_we_o, 32'd0);
        @(negedge clk_i);
        chk("mul_en_c2", mult_en_o, 32'd1);
        chk("mul_ready_c2", instr_ready_o, 32'd0);
        @(negedge clk_i);
        chk("mul_en_c3", mult_en_o, 32'd1);
        ex_valid_i = 1'b1;
        regfile_wdata_ex_i = 32'h1234;
        #1 chk("mul_ready_done", instr_ready_o, 32'd0);
        @(negedge clk_i);
        ex_valid_i = 1'b0;
        chk("mul_en_off", mult_en_o, 32'd0);
        chk("mul_we", rf_we_o, 32'd1);
        chk("mul_waddr", rf_waddr_o, 32'd4);
        chk("mul_wdata", rf_wdata_o, 32'h1234);
        chk("mul_idle", busy_o, 32'd0);
        chk("mul_stall_cnt", md_stall_cnt_o, CNT_EN ? 32'd2 : 32'd0);
        @(negedge clk_i);
        chk("mul_we_pulse", rf_we_o, 32'd0);

        // DIV x8 flushed together with ex_valid
        drive_op(ALU_ADD, MD_OP_DIV, 1'b0, 1'b1, 32'd100, 32'd7, 1'b1, 5'd8);
        @(negedge clk_i);
        drop_valid();
        chk("div_en", div_en_o, 32'd1);
        chk("div_md_op", multdiv_operator_o, MD_OP_DIV);
        @(negedge clk_i);
        ex_valid_i = 1'b1;
        flush_i = 1'b1;
        regfile_wdata_ex_i = 32'hdead;
        #1 chk("flush_ready", instr_ready_o, 32'd0);
        @(negedge clk_i);
        ex_valid_i = 1'b0;
        flush_i = 1'b0;
        chk("flush_div_en", div_en_o, 32'd0);
        chk("flush_busy", busy_o, 32'd0);
        chk("flush_no_we", rf_we_o, 32'd0);
        chk("flush_stall_cnt", md_stall_cnt_o, CNT_EN ? 32'd3 : 32'd0);
        @(negedge clk_i);
        chk("flush_no_we2", rf_we_o, 32'd0);

        // writes to x0 and non-writing ops retire silently
        ex_valid_i = 1'b1;
        regfile_wdata_ex_i = 32'h55;
        drive_op(ALU_OR, MD_OP_MULL, 1'b0, 1'b0, 32'd9, 32'd9, 1'b1, 5'd0);
        @(negedge clk_i);
        drive_op(ALU_AND, MD_OP_MULL, 1'b0, 1'b0, 32'd9, 32'd9, 1'b0, 5'd9);
        chk("x0_busy", busy_o, 32'd1);
        @(negedge clk_i);
        drop_valid();
        chk("x0_no_we", rf_we_o, 32'd0);
        @(negedge clk_i);
        chk("nowe_no_we", rf_we_o, 32'd0);
        chk("nowe_idle", busy_o, 32'd0);
        chk("nowe_waddr_kept", rf_waddr_o, 32'd8 - 32'd4);
        ex_valid_i = 1'b0;

        // reset during a DIV stall
        drive_op(ALU_SLL, MD_OP_REM, 1'b0, 1'b1, 32'd77, 32'd3, 1'b1, 5'd11);
        @(negedge clk_i);
        drop_valid();
        chk("rdiv_en", div_en_o, 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("rdiv_en_async", div_en_o, 32'd0);
        chk("rdiv_busy", busy_o, 32'd0);
        chk("rdiv_ready", instr_ready_o, 32'd1);
        chk("rdiv_opa", alu_operand_a_o, 32'd0);
        chk("rdiv_mdb", multdiv_operand_b_o, 32'd0);
        chk("rdiv_alu_op", alu_operator_o, ALU_ADD);
        chk("rdiv_md_op", multdiv_operator_o, MD_OP_MULL);
        chk("rdiv_waddr", rf_waddr_o, 32'd0);
        chk("rdiv_stall", md_stall_cnt_o, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        chk("rdiv_no_we", rf_we_o, 32'd0);
        drive_op(ALU_ADD, MD_OP_MULL, 1'b0, 1'b0, 32'd2, 32'd3, 1'b1, 5'd10);
        ex_valid_i = 1'b1;
        regfile_wdata_ex_i = 32'd5;
        @(negedge clk_i);
        drop_valid();
        chk("post_rst_opa", alu_operand_a_o, 32'd2);
        @(negedge clk_i);
        chk("post_rst_we", rf_we_o, 32'd1);
        chk("post_rst_waddr", rf_waddr_o, 32'd10);
        chk("post_rst_wdata", rf_wdata_o, 32'd5);
        ex_valid_i = 1'b0;
        @(negedge clk_i);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
